// File: rtl/stage3_seq.sv
// -----------------------------------------------------------------------------
// stage3_seq
// Third radix-2 DIT stage of a 32-point FFT. It consumes the 32 complex words
// from stage2 and computes 16 butterflies on the pairs (8g+o, 8g+o+4) with
// twiddle W32^(4*o). A single complex butterfly is time-multiplexed across the
// 16 pairs through a 3-stage pipeline:
//   A: fetch operands and twiddle
//   B: complex multiply
//   C: add/subtract, then saturate
//
// Ports
//   clk_MAC  in   1      rising-edge clock
//   rst      in   1      asynchronous active-low reset
//   start    in   1      run request, sampled only while idle
//   in_re    in   32*DW  stage2 real words, word k at [DW*k +: DW]
//   in_im    in   32*DW  stage2 imaginary words, same packing
//   busy     out  1      high whenever the FSM is not idle
//   done     out  1      one-cycle pulse when out_re/out_im are complete
//   out_re   out  32*DW  stage3 real results, same packing
//   out_im   out  32*DW  stage3 imaginary results, same packing
// -----------------------------------------------------------------------------
module stage3_seq #(
    parameter int DW    = 16,
    parameter int TW_FB = 14,
    parameter int NBF   = 16
) (
    input  logic              clk_MAC,
    input  logic              rst,
    input  logic              start,
    input  logic [32*DW-1:0]  in_re,
    input  logic [32*DW-1:0]  in_im,
    output logic              busy,
    output logic              done,
    output logic [32*DW-1:0]  out_re,
    output logic [32*DW-1:0]  out_im
);

    localparam int WW   = 16;            // Q1.14 twiddle word
    localparam int PRW  = DW + WW;       // full product width
    localparam int SW   = PRW + 1;       // product sum/difference width
    localparam int PW   = SW - TW_FB;    // scaled product width (keeps all integer bits)
    localparam int SUMW = PW + 1;        // butterfly add/sub width
    localparam logic [4:0] LAST_J    = 5'(NBF - 1);
    localparam logic [4:0] DRAIN_END = 5'(NBF + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Twiddle ROM, packed {re, im}: W0, W4, W8, W12 of a 32-point FFT
    function automatic logic [2*WW-1:0] twiddle(input logic [1:0] o);
        logic [2*WW-1:0] w;
        case (o)
            2'd0:    w = {16'sh4000, 16'sh0000};
            2'd1:    w = {16'sh2D41, 16'shD2BF};
            2'd2:    w = {16'sh0000, 16'shC000};
            2'd3:    w = {16'shD2BF, 16'shD2BF};
            default: w = {16'sh4000, 16'sh0000};
        endcase
        return w;
    endfunction

    // Clamp a wide two's-complement sum to the DW-bit output range
    function automatic logic [DW-1:0] sat_dw(input logic [SUMW-1:0] x);
        logic [DW-1:0] r;
        if ((x[SUMW-1:DW-1] == {(SUMW-DW+1){1'b0}}) ||
            (x[SUMW-1:DW-1] == {(SUMW-DW+1){1'b1}})) begin
            r = x[DW-1:0];
        end else if (x[SUMW-1]) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = {1'b0, {(DW-1){1'b1}}};
        end
        return r;
    endfunction

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        accept_s;

    logic [DW-1:0] bank_re_q [32];
    logic [DW-1:0] bank_im_q [32];
    logic [DW-1:0] out_re_q  [32];
    logic [DW-1:0] out_im_q  [32];

    // Pipe A registers
    logic                 vld_a_q;
    logic [3:0]           idx_a_q;
    logic signed [DW-1:0] a_re_a_q, a_im_a_q, b_re_a_q, b_im_a_q;
    logic signed [WW-1:0] w_re_a_q, w_im_a_q;

    // Pipe B registers
    logic                 vld_b_q;
    logic [3:0]           idx_b_q;
    logic [DW-1:0]        a_re_b_q, a_im_b_q;
    logic [PW-1:0]        p_re_q, p_im_q;

    // Combinational next values
    logic [4:0]           t_idx_s, b_idx_s;
    logic [2*WW-1:0]      w_s;
    logic signed [PRW-1:0] m_rr_s, m_ii_s, m_ri_s, m_ir_s;
    logic [SW-1:0]        s_re_s, s_im_s;
    logic [PW-1:0]        p_re_d, p_im_d;
    logic [4:0]           t_c_s, b_c_s;
    logic [SUMW-1:0]      a_re_x_s, a_im_x_s, p_re_x_s, p_im_x_s;
    logic [DW-1:0]        top_re_d, top_im_d, bot_re_d, bot_im_d;

    assign accept_s = (state_q == S_IDLE) && start;
    assign busy     = busy_q;
    assign done     = done_q;

    // Control FSM with registered busy/done
    always_ff @(posedge clk_MAC or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    cnt_q  <= 5'd0;
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // cnt keeps counting through DRAIN so it also times the pipeline flush
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_J) begin
                        state_q <= S_DRAIN;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_DRAIN: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == DRAIN_END) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 5'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 5'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Input bank: snapshot of stage2 taken on the accepting edge
    always_ff @(posedge clk_MAC or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 32; k++) begin
                bank_re_q[k] <= {DW{1'b0}};
                bank_im_q[k] <= {DW{1'b0}};
            end
        end else if (accept_s) begin
            for (int k = 0; k < 32; k++) begin
                bank_re_q[k] <= in_re[DW*k +: DW];
                bank_im_q[k] <= in_im[DW*k +: DW];
            end
        end else begin
            for (int k = 0; k < 32; k++) begin
                bank_re_q[k] <= bank_re_q[k];
                bank_im_q[k] <= bank_im_q[k];
            end
        end
    end

    // Operand addressing and butterfly arithmetic
    always_comb begin
        // butterfly j = {g, o}: top = 8g + o, bottom = top + 4
        t_idx_s = {cnt_q[3:2], 1'b0, cnt_q[1:0]};
        b_idx_s = {cnt_q[3:2], 1'b1, cnt_q[1:0]};
        w_s     = twiddle(cnt_q[1:0]);

        m_rr_s = b_re_a_q * w_re_a_q;
        m_ii_s = b_im_a_q * w_im_a_q;
        m_ri_s = b_re_a_q * w_im_a_q;
        m_ir_s = b_im_a_q * w_re_a_q;
        s_re_s = {m_rr_s[PRW-1], m_rr_s} - {m_ii_s[PRW-1], m_ii_s};
        s_im_s = {m_ri_s[PRW-1], m_ri_s} + {m_ir_s[PRW-1], m_ir_s};
        // dropping the fraction bits is an arithmetic shift (floor)
        p_re_d = s_re_s[SW-1:TW_FB];
        p_im_d = s_im_s[SW-1:TW_FB];

        t_c_s    = {idx_b_q[3:2], 1'b0, idx_b_q[1:0]};
        b_c_s    = {idx_b_q[3:2], 1'b1, idx_b_q[1:0]};
        a_re_x_s = {{(SUMW-DW){a_re_b_q[DW-1]}}, a_re_b_q};
        a_im_x_s = {{(SUMW-DW){a_im_b_q[DW-1]}}, a_im_b_q};
        p_re_x_s = {p_re_q[PW-1], p_re_q};
        p_im_x_s = {p_im_q[PW-1], p_im_q};
        top_re_d = sat_dw(a_re_x_s + p_re_x_s);
        top_im_d = sat_dw(a_im_x_s + p_im_x_s);
        bot_re_d = sat_dw(a_re_x_s - p_re_x_s);
        bot_im_d = sat_dw(a_im_x_s - p_im_x_s);
    end

    // Pipe A: one butterfly issued per RUN cycle
    always_ff @(posedge clk_MAC or negedge rst) begin
        if (!rst) begin
            vld_a_q  <= 1'b0;
            idx_a_q  <= 4'd0;
            a_re_a_q <= {DW{1'b0}};
            a_im_a_q <= {DW{1'b0}};
            b_re_a_q <= {DW{1'b0}};
            b_im_a_q <= {DW{1'b0}};
            w_re_a_q <= {WW{1'b0}};
            w_im_a_q <= {WW{1'b0}};
        end else if (state_q == S_RUN) begin
            vld_a_q  <= 1'b1;
            idx_a_q  <= cnt_q[3:0];
            a_re_a_q <= bank_re_q[t_idx_s];
            a_im_a_q <= bank_im_q[t_idx_s];
            b_re_a_q <= bank_re_q[b_idx_s];
            b_im_a_q <= bank_im_q[b_idx_s];
            w_re_a_q <= w_s[2*WW-1:WW];
            w_im_a_q <= w_s[WW-1:0];
        end else begin
            vld_a_q  <= 1'b0;
        end
    end

    // Pipe B: twiddle product, top operand carried alongside
    always_ff @(posedge clk_MAC or negedge rst) begin
        if (!rst) begin
            vld_b_q  <= 1'b0;
            idx_b_q  <= 4'd0;
            a_re_b_q <= {DW{1'b0}};
            a_im_b_q <= {DW{1'b0}};
            p_re_q   <= {PW{1'b0}};
            p_im_q   <= {PW{1'b0}};
        end else if (vld_a_q) begin
            vld_b_q  <= 1'b1;
            idx_b_q  <= idx_a_q;
            a_re_b_q <= a_re_a_q;
            a_im_b_q <= a_im_a_q;
            p_re_q   <= p_re_d;
            p_im_q   <= p_im_d;
        end else begin
            vld_b_q  <= 1'b0;
        end
    end

    // Pipe C: write both butterfly outputs into the result bank
    always_ff @(posedge clk_MAC or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 32; k++) begin
                out_re_q[k] <= {DW{1'b0}};
                out_im_q[k] <= {DW{1'b0}};
            end
        end else if (vld_b_q) begin
            out_re_q[t_c_s] <= top_re_d;
            out_im_q[t_c_s] <= top_im_d;
            out_re_q[b_c_s] <= bot_re_d;
            out_im_q[b_c_s] <= bot_im_d;
        end else begin
            for (int k = 0; k < 32; k++) begin
                out_re_q[k] <= out_re_q[k];
                out_im_q[k] <= out_im_q[k];
            end
        end
    end

    for (genvar k = 0; k < 32; k++) begin : g_pack
        assign out_re[DW*k +: DW] = out_re_q[k];
        assign out_im[DW*k +: DW] = out_im_q[k];
    end

endmodule

// File: tb/tb_stage3_seq.sv
// Directed and random bench for stage3_seq: table of single-pair vectors with
// hand-computed results, start-hold, mid-run reset, and random runs against an
// arithmetic model.
module tb_stage3_seq;

    logic          clk_MAC = 1'b0;
    logic          rst;
    logic          start;
    logic [511:0]  in_re, in_im;
    logic          busy, done;
    logic [511:0]  out_re, out_im;

    int n_tests = 0;
    int n_fail  = 0;

    stage3_seq dut (
        .clk_MAC (clk_MAC),
        .rst     (rst),
        .start   (start),
        .in_re   (in_re),
        .in_im   (in_im),
        .busy    (busy),
        .done    (done),
        .out_re  (out_re),
        .out_im  (out_im)
    );

    always #5 clk_MAC = ~clk_MAC;

    typedef struct {
        int t;
        int ar, ai, br, bi;
        int etr, eti, ebr, ebi;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [511:0] set_word(input logic [511:0] v, input int k, input int val);
        logic [511:0] r;
        r = v;
        r[16*k +: 16] = 16'(val);
        return r;
    endfunction

    function automatic int get_word(input logic [511:0] v, input int k);
        logic signed [15:0] w;
        w = v[16*k +: 16];
        return int'(w);
    endfunction

    function automatic int sat16(input longint x);
        if (x > 32767) return 32767;
        else if (x < -32768) return -32768;
        else return int'(x);
    endfunction

    task automatic model(input logic [511:0] r, input logic [511:0] i,
                         output logic [511:0] er, output logic [511:0] ei);
        int wre [4] = '{16384, 11585, 0, -11585};
        int wim [4] = '{0, -11585, -16384, -11585};
        er = '0;
        ei = '0;
        for (int j = 0; j < 16; j++) begin
            int o, t, b;
            longint ar, ai, br, bi, pr, pim;
            o  = j % 4;
            t  = 8 * (j / 4) + o;
            b  = t + 4;
            ar = get_word(r, t);  ai = get_word(i, t);
            br = get_word(r, b);  bi = get_word(i, b);
            pr  = (br * wre[o] - bi * wim[o]) >>> 14;
            pim = (br * wim[o] + bi * wre[o]) >>> 14;
            er = set_word(er, t, sat16(ar + pr));
            ei = set_word(ei, t, sat16(ai + pim));
            er = set_word(er, b, sat16(ar - pr));
            ei = set_word(ei, b, sat16(ai - pim));
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bank(input string name, input logic [511:0] er, input logic [511:0] ei);
        int bad;
        bad = -1;
        n_tests++;
        for (int k = 63; k >= 0; k--) begin
            if (k < 32) begin
                if (out_re[16*k +: 16] !== er[16*k +: 16]) bad = k;
            end else begin
                if (out_im[16*(k-32) +: 16] !== ei[16*(k-32) +: 16]) bad = k;
            end
        end
        if (bad >= 0) begin
            n_fail++;
            if (bad < 32)
                $display("FAIL %s: out_re[%0d] got %0d, expected %0d", name, bad,
                         get_word(out_re, bad), get_word(er, bad));
            else
                $display("FAIL %s: out_im[%0d] got %0d, expected %0d", name, bad - 32,
                         get_word(out_im, bad - 32), get_word(ei, bad - 32));
        end
    endtask

    // One complete run: accept at E0, sample #1 after E1..E19.
    task automatic run(input logic [511:0] r, input logic [511:0] i,
                       output int lat, output int proto_err);
        @(negedge clk_MAC);
        in_re = r;
        in_im = i;
        start = 1'b1;
        @(posedge clk_MAC);
        #1;
        start = 1'b0;
        in_re = {16{$urandom}};
        in_im = {16{$urandom}};
        lat = 0;
        proto_err = 0;
        if (busy !== 1'b1 || done !== 1'b0) proto_err++;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk_MAC);
            #1;
            if (done === 1'b1 && lat == 0) lat = k;
            if ((done === 1'b1) != (k == 18)) proto_err++;
            if ((busy === 1'b1) != (k <= 18)) proto_err++;
        end
    endtask

    initial begin
        logic [511:0] r, i, er, ei;
        int lat, perr, ndone, nlow, dpos [3];

        // t, a(re,im), b(re,im), expected top(re,im), bottom(re,im)
        vecs[0] = '{0,  1000, 0, 0, 0,            1000, 0, 1000, 0};
        vecs[1] = '{0,  0, 0, 16384, 0,           16384, 0, -16384, 0};
        vecs[2] = '{1,  0, 0, 1000, 0,            707, -708, -707, 708};
        vecs[3] = '{2,  0, 0, 16384, 0,           0, -16384, 0, 16384};
        vecs[4] = '{0,  30000, 0, 16384, 0,       32767, 0, 13616, 0};
        vecs[5] = '{0,  -30000, 0, -16384, 0,     -32768, 0, -13616, 0};
        vecs[6] = '{11, 100, 200, 0, 16384,       11685, -11385, -11485, 11785};
        vecs[7] = '{26, -5, 7, 3, -2,             -7, 4, -3, 10};
        vecs[8] = '{1,  0, 0, -1, 0,              -1, 0, 1, 0};
        vecs[9] = '{19, 0, -32768, -32768, -32768, 0, 13572, 0, -32768};

        rst   = 1'b0;
        start = 1'b0;
        in_re = '0;
        in_im = '0;
        repeat (3) @(posedge clk_MAC);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check_bank("reset_out", '0, '0);
        @(negedge clk_MAC);
        rst = 1'b1;

        // Table-driven single-pair vectors
        for (int v = 0; v < 10; v++) begin
            r  = '0;  i  = '0;  er = '0;  ei = '0;
            r  = set_word(r, vecs[v].t, vecs[v].ar);
            i  = set_word(i, vecs[v].t, vecs[v].ai);
            r  = set_word(r, vecs[v].t + 4, vecs[v].br);
            i  = set_word(i, vecs[v].t + 4, vecs[v].bi);
            er = set_word(er, vecs[v].t, vecs[v].etr);
            ei = set_word(ei, vecs[v].t, vecs[v].eti);
            er = set_word(er, vecs[v].t + 4, vecs[v].ebr);
            ei = set_word(ei, vecs[v].t + 4, vecs[v].ebi);
            run(r, i, lat, perr);
            check($sformatf("vec%0d_latency", v), lat, 18);
            check($sformatf("vec%0d_busy_done", v), perr, 0);
            check_bank($sformatf("vec%0d_out", v), er, ei);
            repeat (3) @(posedge clk_MAC);
            #1;
            check_bank($sformatf("vec%0d_hold", v), er, ei);
        end

        // start held high for 60 cycles: back-to-back runs with one idle cycle
        ndone = 0;
        nlow  = 0;
        dpos  = '{-1, -1, -1};
        @(negedge clk_MAC);
        start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk_MAC);
            #1;
            if (done === 1'b1) begin
                if (ndone < 3) dpos[ndone] = c;
                ndone++;
            end
            if (busy !== 1'b1) nlow++;
        end
        @(negedge clk_MAC);
        start = 1'b0;
        check("hold_done_count", ndone, 3);
        check("hold_done0_cycle", dpos[0], 18);
        check("hold_done1_cycle", dpos[1], 38);
        check("hold_done2_cycle", dpos[2], 58);
        check("hold_busy_low_cycles", nlow, 3);

        // Reset in the middle of a run
        r = {16{$urandom}};
        i = {16{$urandom}};
        @(negedge clk_MAC);
        in_re = r;
        in_im = i;
        start = 1'b1;
        @(posedge clk_MAC);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk_MAC);
        #1;
        rst = 1'b0;
        #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        check_bank("midreset_out", '0, '0);
        @(negedge clk_MAC);
        rst = 1'b1;
        ndone = 0;
        nlow  = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk_MAC);
            #1;
            if (done === 1'b1) ndone++;
            if (busy === 1'b1) nlow++;
        end
        check("after_reset_no_done", ndone, 0);
        check("after_reset_no_busy", nlow, 0);
        model(r, i, er, ei);
        run(r, i, lat, perr);
        check("recover_latency", lat, 18);
        check("recover_busy_done", perr, 0);
        check_bank("recover_out", er, ei);

        // Random runs against the model, with extra full-scale words
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 32; k++) begin
                int sel;
                sel = int'($urandom_range(0, 7));
                r = set_word(r, k, (sel == 0) ? -32768 : (sel == 1) ? 32767 : int'($urandom));
                sel = int'($urandom_range(0, 7));
                i = set_word(i, k, (sel == 0) ? -32768 : (sel == 1) ? 32767 : int'($urandom));
            end
            model(r, i, er, ei);
            run(r, i, lat, perr);
            check($sformatf("rand%0d_latency", n), lat, 18);
            check_bank($sformatf("rand%0d_out", n), er, ei);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
